// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//
// Purpose:
//   Load-use hazard detection and EX-stage operand forwarding for the 5-stage
//   integer core, plus optional performance counters.
//   - stall / pc_write_en / if_id_write_en / id_ex_bubble and
//     forward_a / forward_b are purely combinational (zero latency).
//   - Forward select: 00 = register file, 10 = EX/MEM ALU result,
//     01 = MEM/WB write-back value. 11 is never produced.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   Defined   : stall_count, fwd_exmem_count and fwd_memwb_count are
//               saturating event counters.
//               They are clocked on the rising edge of clk and cleared
//               asynchronously by rst_n.
//   Undefined : no counter flops; the three counter outputs are tied to 0.
//
// Ports:
//   clk, rst_n                         core clock / async active-low reset
//   id_ex_mem_read, id_ex_rd_idx       load in ID/EX and its destination
//   if_id_rs1_idx, if_id_rs2_idx       sources of the instruction in IF/ID
//   ex_rs1_idx, ex_rs2_idx             sources of the instruction in EX
//   ex_mem_reg_write, ex_mem_rd_idx    EX/MEM producer
//   mem_wb_reg_write, mem_wb_rd_idx    MEM/WB producer
//   stall, pc_write_en, if_id_write_en, id_ex_bubble    hazard controls
//   forward_a, forward_b               ALU operand source selects
//   stall_count, fwd_exmem_count, fwd_memwb_count      performance counters
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rd_idx,
  input  logic [REG_ADDR_W-1:0] if_id_rs1_idx,
  input  logic [REG_ADDR_W-1:0] if_id_rs2_idx,
  input  logic [REG_ADDR_W-1:0] ex_rs1_idx,
  input  logic [REG_ADDR_W-1:0] ex_rs2_idx,
  input  logic                  ex_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd_idx,
  input  logic                  mem_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd_idx,
  output logic                  stall,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  id_ex_bubble,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      fwd_exmem_count,
  output logic [CNT_W-1:0]      fwd_memwb_count
);

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // EX/MEM is checked first: it holds the youngest producer, so its value
  // supersedes an older write of the same register sitting in MEM/WB.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  em_we,
    input logic [REG_ADDR_W-1:0] em_rd,
    input logic                  mw_we,
    input logic [REG_ADDR_W-1:0] mw_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (em_we && (em_rd != '0) && (em_rd == src))
      sel = FWD_EXMEM;
    else if (mw_we && (mw_rd != '0) && (mw_rd == src))
      sel = FWD_MEMWB;
    return sel;
  endfunction

  logic       w_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // A load to x0 produces nothing to wait for, so it never stalls.
  assign w_stall = id_ex_mem_read && (id_ex_rd_idx != '0) &&
                   ((id_ex_rd_idx == if_id_rs1_idx) ||
                    (id_ex_rd_idx == if_id_rs2_idx));

  assign w_fwd_a = fwd_sel(ex_rs1_idx, ex_mem_reg_write, ex_mem_rd_idx,
                           mem_wb_reg_write, mem_wb_rd_idx);
  assign w_fwd_b = fwd_sel(ex_rs2_idx, ex_mem_reg_write, ex_mem_rd_idx,
                           mem_wb_reg_write, mem_wb_rd_idx);

  assign stall          = w_stall;
  assign pc_write_en    = ~w_stall;
  assign if_id_write_en = ~w_stall;
  assign id_ex_bubble   = w_stall;
  assign forward_a      = w_fwd_a;
  assign forward_b      = w_fwd_b;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_any_exmem;
  logic             w_any_memwb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_exmem_cnt;
  logic [CNT_W-1:0] r_memwb_cnt;

  // One increment per cycle even when both operands use the same source.
  assign w_any_exmem = (w_fwd_a == FWD_EXMEM) || (w_fwd_b == FWD_EXMEM);
  assign w_any_memwb = (w_fwd_a == FWD_MEMWB) || (w_fwd_b == FWD_MEMWB);

  // Counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_exmem_cnt <= '0;
      r_memwb_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_any_exmem && (r_exmem_cnt != CNT_MAX))
        r_exmem_cnt <= r_exmem_cnt + CNT_ONE;
      if (w_any_memwb && (r_memwb_cnt != CNT_MAX))
        r_memwb_cnt <= r_memwb_cnt + CNT_ONE;
    end
  end

  assign stall_count     = r_stall_cnt;
  assign fwd_exmem_count = r_exmem_cnt;
  assign fwd_memwb_count = r_memwb_cnt;
`else
  // Clock and reset only feed the counters; keep them referenced.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = &{1'b0, clk, rst_n};

  assign stall_count     = '0;
  assign fwd_exmem_count = '0;
  assign fwd_memwb_count = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  localparam int AW = 5;
  localparam int CW = 4;   // narrow counters so saturation is reachable
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_ex_mem_read;
  logic [AW-1:0] id_ex_rd_idx, if_id_rs1_idx, if_id_rs2_idx;
  logic [AW-1:0] ex_rs1_idx, ex_rs2_idx;
  logic          ex_mem_reg_write, mem_wb_reg_write;
  logic [AW-1:0] ex_mem_rd_idx, mem_wb_rd_idx;
  logic          stall, pc_write_en, if_id_write_en, id_ex_bubble;
  logic [1:0]    forward_a, forward_b;
  logic [CW-1:0] stall_count, fwd_exmem_count, fwd_memwb_count;

  hazard_forward_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd_idx(id_ex_rd_idx),
    .if_id_rs1_idx(if_id_rs1_idx), .if_id_rs2_idx(if_id_rs2_idx),
    .ex_rs1_idx(ex_rs1_idx), .ex_rs2_idx(ex_rs2_idx),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd_idx(ex_mem_rd_idx),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd_idx(mem_wb_rd_idx),
    .stall(stall), .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .id_ex_bubble(id_ex_bubble), .forward_a(forward_a), .forward_b(forward_b),
    .stall_count(stall_count), .fwd_exmem_count(fwd_exmem_count),
    .fwd_memwb_count(fwd_memwb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
    int         c_stall;
    int         c_exmem;
    int         c_memwb;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_stall = 0, m_exmem = 0, m_memwb = 0;
  int   cnt_max = (1 << CW) - 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the producers are listed youngest first; the first one that
  // writes a non-zero register equal to the source supplies the operand.
  function automatic logic [1:0] ref_src(input logic [AW-1:0] src);
    logic          we[2];
    logic [AW-1:0] rd[2];
    logic [1:0]    code[2];
    we[0] = ex_mem_reg_write; rd[0] = ex_mem_rd_idx; code[0] = 2'b10;
    we[1] = mem_wb_reg_write; rd[1] = mem_wb_rd_idx; code[1] = 2'b01;
    for (int p = 0; p < 2; p++)
      if (we[p] && rd[p] != 0 && rd[p] == src) return code[p];
    return 2'b00;
  endfunction

  function automatic logic ref_stall();
    if (!id_ex_mem_read || id_ex_rd_idx == 0) return 1'b0;
    return (id_ex_rd_idx == if_id_rs1_idx) || (id_ex_rd_idx == if_id_rs2_idx);
  endfunction

  function automatic int sat_inc(input int v, input bit ev);
    if (ev && v < cnt_max) return v + 1;
    return v;
  endfunction

  // Accounts for the rising edge just passed, applies new inputs and
  // records what the DUT should present during this cycle.
  task automatic step(input bit rst_v, input bit mr, input int idrd,
                      input int r1, input int r2, input int e1, input int e2,
                      input bit emw, input int emrd, input bit mww, input int mwrd);
    logic [1:0] fa, fb;
    exp_t e;
    @(posedge clk);
    #1;
    fa = ref_src(ex_rs1_idx);
    fb = ref_src(ex_rs2_idx);
    if (rst_n) begin
      m_stall = sat_inc(m_stall, ref_stall());
      m_exmem = sat_inc(m_exmem, (fa == 2'b10) || (fb == 2'b10));
      m_memwb = sat_inc(m_memwb, (fa == 2'b01) || (fb == 2'b01));
    end
    rst_n = rst_v;
    if (!rst_v) begin m_stall = 0; m_exmem = 0; m_memwb = 0; end
    id_ex_mem_read = mr;  id_ex_rd_idx = AW'(idrd);
    if_id_rs1_idx = AW'(r1); if_id_rs2_idx = AW'(r2);
    ex_rs1_idx = AW'(e1); ex_rs2_idx = AW'(e2);
    ex_mem_reg_write = emw; ex_mem_rd_idx = AW'(emrd);
    mem_wb_reg_write = mww; mem_wb_rd_idx = AW'(mwrd);
    e.stall = ref_stall();
    e.fa = ref_src(ex_rs1_idx);
    e.fb = ref_src(ex_rs2_idx);
    e.c_stall = PERF ? m_stall : 0;
    e.c_exmem = PERF ? m_exmem : 0;
    e.c_memwb = PERF ? m_memwb : 0;
    exp_q.push_back(e);
  endtask

  task automatic rand_step(input bit rst_v);
    step(rst_v, ($urandom_range(0, 1) == 1), $urandom_range(0, 7),
         $urandom_range(0, 7), $urandom_range(0, 7),
         $urandom_range(0, 7), $urandom_range(0, 7),
         ($urandom_range(0, 1) == 1), $urandom_range(0, 7),
         ($urandom_range(0, 1) == 1), $urandom_range(0, 7));
  endtask

  // Monitor: outputs are stable from 1 ns after the rising edge onward.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", int'(stall), int'(e.stall));
      chk("pc_write_en", int'(pc_write_en), int'(!e.stall));
      chk("if_id_write_en", int'(if_id_write_en), int'(!e.stall));
      chk("id_ex_bubble", int'(id_ex_bubble), int'(e.stall));
      chk("forward_a", int'(forward_a), int'(e.fa));
      chk("forward_b", int'(forward_b), int'(e.fb));
      chk("stall_count", int'(stall_count), e.c_stall);
      chk("fwd_exmem_count", int'(fwd_exmem_count), e.c_exmem);
      chk("fwd_memwb_count", int'(fwd_memwb_count), e.c_memwb);
    end
  end

  initial begin
    rst_n = 1'b0;
    id_ex_mem_read = 0; id_ex_rd_idx = 0; if_id_rs1_idx = 0; if_id_rs2_idx = 0;
    ex_rs1_idx = 0; ex_rs2_idx = 0; ex_mem_reg_write = 0; ex_mem_rd_idx = 0;
    mem_wb_reg_write = 0; mem_wb_rd_idx = 0;
    #2;
    chk("reset stall_count", int'(stall_count), 0);
    chk("reset fwd_exmem_count", int'(fwd_exmem_count), 0);
    chk("reset fwd_memwb_count", int'(fwd_memwb_count), 0);
    chk("reset stall", int'(stall), 0);

    // Directed cases: args are rst, mr, idrd, r1, r2, e1, e2, emw, emrd, mww, mwrd
    step(1, 0, 5, 3, 4, 2, 3, 0, 0, 0, 0);   // no hazard, no forward
    step(1, 1, 3, 3, 4, 2, 3, 0, 0, 0, 0);   // load-use on rs1
    step(1, 1, 3, 3, 4, 2, 3, 0, 0, 0, 0);
    step(1, 1, 4, 3, 4, 2, 3, 0, 0, 0, 0);   // load-use on rs2
    step(1, 1, 3, 3, 3, 2, 3, 0, 0, 0, 0);   // both sources match
    step(1, 1, 0, 0, 0, 2, 3, 0, 0, 0, 0);   // load to x0
    step(1, 0, 3, 3, 3, 7, 3, 1, 7, 0, 0);   // EX/MEM on A
    step(1, 0, 0, 0, 0, 2, 8, 0, 0, 1, 8);   // MEM/WB on B
    step(1, 0, 0, 0, 0, 6, 6, 1, 6, 1, 6);   // EX/MEM wins on both
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);   // x0 never forwards
    step(1, 0, 0, 0, 0, 9, 9, 0, 9, 0, 9);   // rd match without regWrite
    step(1, 0, 0, 0, 0, 4, 5, 1, 4, 1, 5);   // A from EX/MEM, B from MEM/WB

    // Randomized traffic; long enough to drive every narrow counter to saturation.
    for (int i = 0; i < 120; i++) rand_step(1);
    for (int i = 0; i < 20; i++) step(1, 1, 9, 9, 1, 9, 9, 1, 9, 0, 0);

    // Reset mid-count: counters must clear before any clock edge.
    step(0, 1, 9, 9, 1, 9, 9, 1, 9, 0, 0);
    #1;
    chk("async clear stall_count", int'(stall_count), 0);
    chk("async clear fwd_exmem_count", int'(fwd_exmem_count), 0);
    chk("async clear fwd_memwb_count", int'(fwd_memwb_count), 0);
    step(0, 1, 9, 9, 1, 9, 9, 1, 9, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 9, 9, 1, 2, 3, 0, 0, 1, 3);
    for (int i = 0; i < 150; i++) rand_step(($urandom_range(0, 29) != 0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
